// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan encoder.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_e;

  // Key code layout is {row, col}, so it doubles as the snapshot bit index.
  function automatic logic [3:0] pack_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Keypad-side and consumer-side signals of the scan encoder.
interface keypad_scan_encoder_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_i;
  logic [NUM_COLS-1:0] col_o;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_held;

  modport master (
    input  row_i,
    output col_o,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_i,
    input  col_o,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
module keypad_sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Rows idle high (pull-ups), so reset to "no key closed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner with debounced single-key encoding.
import keypad_pkg::*;

module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  RESET,
  keypad_scan_encoder_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      snap_q, snap_d;
  logic             slot_end;
  logic             scan_done;
  logic [4:0]       low_cnt;
  logic [3:0]       single_code;
  logic             is_none;
  logic             is_single;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cand_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  keypad_sync2 u_sync (
    .clk   (clk),
    .rst_n (RESET),
    .d_i   (kp.row_i),
    .q_o   (row_sync)
  );

  // Slot divider, column stepping and snapshot capture at the end of each slot.
  always_comb begin
    slot_end  = (div_q == DIV_LAST);
    div_d     = slot_end ? '0 : div_q + 1'b1;
    col_d     = slot_end ? col_q + 2'd1 : col_q;
    scan_done = slot_end && (col_q == 2'd3);
    snap_d    = snap_q;
    if (slot_end) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_d[pack_code(2'(r), col_q)] = row_sync[r];
      end
    end
  end

  // Classify the completed scan (uses the snapshot including the column just sampled).
  always_comb begin
    low_cnt     = '0;
    single_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snap_d[i]) begin
        low_cnt     = low_cnt + 5'd1;
        single_code = 4'(i);
      end
    end
    is_none   = (low_cnt == 5'd0);
    is_single = (low_cnt == 5'd1);
  end

  // Scan position and snapshot registers.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      div_q  <= '0;
      col_q  <= '0;
      snap_q <= '1;
    end else begin
      div_q  <= div_d;
      col_q  <= col_d;
      snap_q <= snap_d;
    end
  end

  // Debounce FSM, stepped once per full scan; all key outputs are registered here.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        unique case (state_q)
          IDLE: begin
            if (is_single) begin
              cand_q <= single_code;
              if (DEBOUNCE_SCANS == 1) begin
                state_q     <= HELD;
                cnt_q       <= '0;
                key_code_q  <= single_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= PRESS_CHK;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          PRESS_CHK: begin
            if (is_single && (single_code == cand_q)) begin
              if (cnt_q == DB_LAST) begin
                state_q     <= HELD;
                cnt_q       <= '0;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end else if (is_single) begin
              cand_q <= single_code;
              cnt_q  <= CNT_ONE;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          HELD: begin
            if (is_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                state_q <= REL_CHK;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          REL_CHK: begin
            if (is_none) begin
              if (cnt_q == DB_LAST) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end else begin
              state_q <= HELD;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign kp.col_o     = ~(4'b0001 << col_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
Scans a 4x4 active-low matrix keypad and encodes one debounced key press into a 4-bit hex code with a one-cycle valid strobe. It is the input-side counterpart of the hex-to-seven-segment path. Its key_code output feeds the BCD7-style display and counter logic directly, replacing the single debounced KEY input with 16 keys.

Parameters:
SCAN_DIV, 4, clk cycles per column slot; minimum 4 so that row synchronisation settles inside a slot.
DEBOUNCE_SCANS, 3, consecutive full scans that must agree before a press or release is accepted; minimum 1.

Ports:
clk  input  1  system clock.
RESET  input  1  asynchronous, active-low reset.
row_i  input  4  keypad rows; pulled up externally, 0 = key closed in the driven column.
col_o  output  4  keypad column drive, one-cold (exactly one bit 0 while scanning).
key_code  output  4  code of the accepted key = {row_idx[1:0], col_idx[1:0]} (row 1, col 2 -> 4'h6).
key_valid  output  1  one-cycle pulse when a press is accepted.
key_held  output  1  high from acceptance until the release is accepted.

Behaviour:
- Reset (RESET=0, asynchronous) sets: col_o=4'b1110 (column 0), slot divider=0, column index=0, key_code=0, key_valid=0, key_held=0, FSM=IDLE, scan snapshot and debounce counter cleared.
- row_i passes through a 2-flop synchroniser; only the synchronised value is used.
- Divider counts 0..SCAN_DIV-1 per column. On divider==SCAN_DIV-1:
  - the synchronised rows are latched into the snapshot bits for the current column;
  - the column advances 0->1->2->3->0, and col_o updates the next cycle;
  - a full scan completes when column 3 is sampled. Scan period = 4*SCAN_DIV cycles.
- Scan result at completion:
  - NONE: no bit low in the snapshot.
  - SINGLE(code): exactly one bit low.
  - MULTI: two or more bits low. MULTI is treated as NONE for press detection, and as "still pressed" while in HELD or REL_CHK.
- FSM, evaluated only at scan completion:
  - IDLE: SINGLE(c) -> store candidate c, cnt=1, go to PRESS_CHK. Otherwise stay in IDLE.
  - PRESS_CHK:
    - SINGLE(same c) -> cnt++. When cnt reaches DEBOUNCE_SCANS, go to HELD, key_code<=c, key_valid pulses for the next cycle only, key_held<=1.
    - SINGLE(different c') -> restart with candidate c', cnt=1.
    - NONE or MULTI -> IDLE.
    - With DEBOUNCE_SCANS=1, IDLE goes straight to HELD.
  - HELD: NONE -> REL_CHK, cnt=1. Otherwise stay in HELD. A different key pressed while held does not re-trigger and key_code does not change.
  - REL_CHK:
    - NONE -> cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE and key_held<=0.
    - Anything else -> HELD, cnt cleared.
- key_code holds its last accepted value after release; it changes only on acceptance.
- key_valid is never high for two consecutive cycles. There is exactly one pulse per accepted press.
- Reset mid-scan or mid-debounce: everything returns to reset values immediately. No pulse is emitted for a partially debounced key.
- Counter widths: sized with $clog2 of SCAN_DIV and of DEBOUNCE_SCANS+1. No wrap in the debounce counter, which saturates at DEBOUNCE_SCANS.

Decomposition:
- Package keypad_pkg holds the FSM state enum (IDLE, PRESS_CHK, HELD, REL_CHK), NUM_ROWS=4, NUM_COLS=4, and the code-packing function (row, col) -> 4-bit.
- One sub-module, keypad_sync2: a 4-bit two-flop synchroniser with asynchronous active-low reset to 4'b1111.
- Scan/divider logic, snapshot classifier and FSM stay in the top.

Test Plan:
1. Reset with all rows high, then run 200 cycles -> col_o cycles 1110,1101,1011,0111, each held 4 cycles; key_valid=0; key_held=0; key_code=0.
2. Hold row1 low only while col_o[2]=0 (key 6) from cycle 0 -> one key_valid pulse at the end of the 3rd full scan (about cycle 48-52); key_code=4'h6; key_held=1. Release -> key_held falls 3 scans after the first empty scan; no second pulse.
3. Bounce key 6 (present, absent, present on alternate scans) for 10 scans, then hold steady -> no pulse during bouncing; exactly one pulse 3 scans after it becomes stable.
4. Press keys 6 and 9 together from IDLE -> no key_valid. Press 6, wait for acceptance, then add 9 -> key_held stays 1, no new pulse, key_code stays 6.
5. Change from key 6 to key 15 (row3, col3) during PRESS_CHK after 2 scans -> candidate restarts; pulse with key_code=4'hF after 3 further stable scans.
6. Assert RESET=0 mid-PRESS_CHK for 3 cycles, asynchronous to clk -> outputs take reset values immediately; after deassertion a held key needs a full 3 fresh scans before its pulse.
